// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared MEM->WB widths, WB select codes, load sizes and pipeline payload
package mem_wb_stage_pkg;

    localparam int PC_BITS       = 32;
    localparam int REG_ADDR_BITS = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    localparam logic [1:0] LS_WORD = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_BYTE = 2'd2;

    // wb_sel stays a plain 2-bit field so the reserved code 3 can travel down the pipe
    typedef struct packed {
        logic                     reg_write;
        logic [1:0]               wb_sel;
        logic [PC_BITS-1:0]       read_data;
        logic [PC_BITS-1:0]       alu_out;
        logic [REG_ADDR_BITS-1:0] write_reg;
        logic [PC_BITS-1:0]       pc_plus_4;
        logic [1:0]               load_size;
        logic                     load_unsigned;
    } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-side inputs and WB-side outputs of the MEM->WB pipeline register
// Load-extension inputs exist only when MEM_WB_LOAD_EXT_EN is defined.
interface mem_wb_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  stall;
    logic                  flush;
    logic                  valid_m;
    logic                  reg_write_m;
    logic [1:0]            mem_to_reg_m;
    logic [DATA_W-1:0]     read_data_m;
    logic [DATA_W-1:0]     alu_out_m;
    logic [REG_ADDR_W-1:0] write_reg_m;
    logic [DATA_W-1:0]     pc_plus_4m;
`ifdef MEM_WB_LOAD_EXT_EN
    logic [1:0]            load_size_m;
    logic                  load_unsigned_m;
`endif
    logic                  valid_wb;
    logic                  reg_write_wb;
    logic [1:0]            mem_to_reg_wb;
    logic [DATA_W-1:0]     read_data_wb;
    logic [DATA_W-1:0]     alu_out_wb;
    logic [REG_ADDR_W-1:0] write_reg_wb;
    logic [DATA_W-1:0]     pc_plus_4wb;
    logic [DATA_W-1:0]     wb_result;
    logic [CNT_W-1:0]      retire_cnt;

    modport master (
        output stall, flush, valid_m, reg_write_m, mem_to_reg_m, read_data_m, alu_out_m, write_reg_m, pc_plus_4m,
        input  valid_wb, reg_write_wb, mem_to_reg_wb, read_data_wb, alu_out_wb, write_reg_wb, pc_plus_4wb,
               wb_result, retire_cnt
`ifdef MEM_WB_LOAD_EXT_EN
        , output load_size_m, load_unsigned_m
`endif
    );

    modport slave (
        input  stall, flush, valid_m, reg_write_m, mem_to_reg_m, read_data_m, alu_out_m, write_reg_m, pc_plus_4m,
        output valid_wb, reg_write_wb, mem_to_reg_wb, read_data_wb, alu_out_wb, write_reg_wb, pc_plus_4wb,
               wb_result, retire_cnt
`ifdef MEM_WB_LOAD_EXT_EN
        , input load_size_m, load_unsigned_m
`endif
    );

endinterface

// File: rtl/mem_wb_stage_slice.sv
// mem_wb_slice: one valid+payload register stage with reset, flush and stall
module mem_wb_slice
    import mem_wb_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_valid,
    input  mem_wb_payload_t i_payload,
    output logic            o_valid,
    output mem_wb_payload_t o_payload
);

    logic            r_valid;
    mem_wb_payload_t r_payload;

    // Reset clears everything, flush drops only valid, stall holds, otherwise capture upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_valid   <= i_valid;
            r_payload <= i_payload;
        end
    end

    assign o_valid   = r_valid;
    assign o_payload = r_payload;

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: parametrised MEM->WB pipeline register with WB result mux and retire counter
// Optional big-endian byte/half load extension is enabled by defining MEM_WB_LOAD_EXT_EN.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W     = PC_BITS,
    parameter int REG_ADDR_W = REG_ADDR_BITS,
    parameter int DEPTH      = 1,
    parameter int CNT_W      = 32
)(
    input logic           clk,
    input logic           rst,
    mem_wb_stage_if.slave bus
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("mem_wb_stage: DEPTH=%0d outside 1..4", DEPTH);
    end
    if (DATA_W != PC_BITS || REG_ADDR_W != REG_ADDR_BITS) begin : g_bad_width
        $error("mem_wb_stage: DATA_W/REG_ADDR_W must match the shared payload widths");
    end

    logic              w_valid   [DEPTH+1];
    mem_wb_payload_t   w_payload [DEPTH+1];
    mem_wb_payload_t   w_last;
    logic [DATA_W-1:0] w_read_data;
    logic              w_reg_write;
    logic [CNT_W-1:0]  r_retire_cnt;

    assign w_valid[0]   = bus.valid_m;
    assign w_payload[0] = '{
        reg_write:     bus.reg_write_m,
        wb_sel:        bus.mem_to_reg_m,
        read_data:     bus.read_data_m,
        alu_out:       bus.alu_out_m,
        write_reg:     bus.write_reg_m,
        pc_plus_4:     bus.pc_plus_4m,
`ifdef MEM_WB_LOAD_EXT_EN
        load_size:     bus.load_size_m,
        load_unsigned: bus.load_unsigned_m
`else
        load_size:     LS_WORD,
        load_unsigned: 1'b0
`endif
    };

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
        mem_wb_slice u_slice (
            .clk       (clk),
            .rst       (rst),
            .i_stall   (bus.stall),
            .i_flush   (bus.flush),
            .i_valid   (w_valid[i]),
            .i_payload (w_payload[i]),
            .o_valid   (w_valid[i+1]),
            .o_payload (w_payload[i+1])
        );
    end

    assign w_last = w_payload[DEPTH];

`ifdef MEM_WB_LOAD_EXT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [1:0]  w_off;

    assign w_off  = w_last.alu_out[1:0];
    assign w_byte = w_off[1] ? (w_off[0] ? w_last.read_data[7:0] : w_last.read_data[15:8])
                             : (w_off[0] ? w_last.read_data[23:16] : w_last.read_data[31:24]);
    assign w_half = w_off[1] ? w_last.read_data[15:0] : w_last.read_data[31:16];

    // Pick the big-endian lane and extend; misaligned halves and words pass the raw word.
    always_comb begin
        w_read_data = w_last.read_data;
        if (w_last.load_size == LS_BYTE)
            w_read_data = {{(DATA_W-8){!w_last.load_unsigned & w_byte[7]}}, w_byte};
        else if (w_last.load_size == LS_HALF && !w_off[0])
            w_read_data = {{(DATA_W-16){!w_last.load_unsigned & w_half[15]}}, w_half};
    end
`else
    logic w_unused;

    assign w_unused    = ^{w_last.load_size, w_last.load_unsigned};
    assign w_read_data = w_last.read_data;
`endif

    assign w_reg_write = w_valid[DEPTH] & w_last.reg_write & (w_last.write_reg != '0);

    assign bus.valid_wb      = w_valid[DEPTH];
    assign bus.reg_write_wb  = w_reg_write;
    assign bus.mem_to_reg_wb = w_last.wb_sel;
    assign bus.read_data_wb  = w_read_data;
    assign bus.alu_out_wb    = w_last.alu_out;
    assign bus.write_reg_wb  = w_last.write_reg;
    assign bus.pc_plus_4wb   = w_last.pc_plus_4;
    assign bus.retire_cnt    = r_retire_cnt;

    // Select the value written back; the reserved code yields zero.
    always_comb begin
        bus.wb_result = w_last.wb_sel == WB_ALU ? w_last.alu_out :
                        w_last.wb_sel == WB_MEM ? w_read_data :
                        w_last.wb_sel == WB_PC4 ? w_last.pc_plus_4 : '0;
    end

    // Count a retirement when a register-writing instruction actually leaves the last slice.
    always_ff @(posedge clk) begin
        if (rst)
            r_retire_cnt <= '0;
        else if (!bus.flush && !bus.stall && w_reg_write)
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed + random checks of mem_wb_stage (DEPTH=1 and DEPTH=3) against a behavioural model
module tb_mem_wb_stage;

    typedef struct packed {
        bit        v;
        bit        rw;
        bit [1:0]  sel;
        bit [31:0] rd;
        bit [31:0] alu;
        bit [4:0]  wr;
        bit [31:0] pc;
        bit [1:0]  ls;
        bit        lu;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ent_t cur = '0;
    bit   cur_st = 1'b0, cur_fl = 1'b0, cur_rst = 1'b1;
    bit   cmp_on = 1'b0;
    int   errors = 0, checks = 0;

    ent_t        m   [2][4];
    int unsigned cnt [2];

    mem_wb_stage_if if1 ();
    mem_wb_stage_if if3 ();

    mem_wb_stage #(.DEPTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    mem_wb_stage #(.DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    assign rst = cur_rst;
    assign if1.stall = cur_st;          assign if3.stall = cur_st;
    assign if1.flush = cur_fl;          assign if3.flush = cur_fl;
    assign if1.valid_m = cur.v;         assign if3.valid_m = cur.v;
    assign if1.reg_write_m = cur.rw;    assign if3.reg_write_m = cur.rw;
    assign if1.mem_to_reg_m = cur.sel;  assign if3.mem_to_reg_m = cur.sel;
    assign if1.read_data_m = cur.rd;    assign if3.read_data_m = cur.rd;
    assign if1.alu_out_m = cur.alu;     assign if3.alu_out_m = cur.alu;
    assign if1.write_reg_m = cur.wr;    assign if3.write_reg_m = cur.wr;
    assign if1.pc_plus_4m = cur.pc;     assign if3.pc_plus_4m = cur.pc;
`ifdef MEM_WB_LOAD_EXT_EN
    assign if1.load_size_m = cur.ls;    assign if3.load_size_m = cur.ls;
    assign if1.load_unsigned_m = cur.lu; assign if3.load_unsigned_m = cur.lu;
`endif

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Loaded value as WB sees it: pick the big-endian lane by shifting, then extend.
    function automatic bit [31:0] ext_rd(ent_t e);
        bit [31:0] r;
        r = e.rd;
`ifdef MEM_WB_LOAD_EXT_EN
        begin
            int off;
            bit [31:0] sh;
            off = int'(e.alu[1:0]);
            if (e.ls == 2) begin
                sh = e.rd >> (8 * (3 - off));
                r = {24'h0, sh[7:0]};
                if (!e.lu && sh[7]) r = r | 32'hFFFF_FF00;
            end else if (e.ls == 1 && off % 2 == 0) begin
                sh = e.rd >> (16 - 8 * off);
                r = {16'h0, sh[15:0]};
                if (!e.lu && sh[15]) r = r | 32'hFFFF_0000;
            end
        end
`endif
        return r;
    endfunction

    function automatic bit [31:0] exp_res(ent_t e);
        case (e.sel)
            2'd0:    return e.alu;
            2'd1:    return ext_rd(e);
            2'd2:    return e.pc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit retires(ent_t e);
        return e.v && e.rw && e.wr != 0;
    endfunction

    // Reference pipes: an instruction needs DEPTH advancing edges to reach WB.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int d;
            d = k ? 3 : 1;
            if (cur_rst) begin
                for (int j = 0; j < 4; j++) m[k][j] = '0;
                cnt[k] = 0;
            end else if (cur_fl) begin
                for (int j = 0; j < 4; j++) m[k][j].v = 1'b0;
            end else if (!cur_st) begin
                cnt[k] += retires(m[k][d-1]);
                for (int j = 3; j > 0; j--) m[k][j] = m[k][j-1];
                m[k][0] = cur;
            end
        end
    end

    function automatic void cmp(int k, logic v, logic rw, logic [1:0] sel, logic [31:0] rd, logic [31:0] alu,
                                logic [4:0] wr, logic [31:0] pc, logic [31:0] res, logic [31:0] c);
        ent_t  e;
        string n;
        e = m[k][k ? 2 : 0];
        n = k ? "d3" : "d1";
        chk({n, ".valid_wb"}, 32'(v), 32'(e.v));
        chk({n, ".reg_write_wb"}, 32'(rw), 32'(retires(e)));
        chk({n, ".retire_cnt"}, c, cnt[k]);
        if (e.v) begin
            chk({n, ".mem_to_reg_wb"}, 32'(sel), 32'(e.sel));
            chk({n, ".read_data_wb"}, rd, ext_rd(e));
            chk({n, ".alu_out_wb"}, alu, e.alu);
            chk({n, ".write_reg_wb"}, 32'(wr), 32'(e.wr));
            chk({n, ".pc_plus_4wb"}, pc, e.pc);
            chk({n, ".wb_result"}, res, exp_res(e));
        end
    endfunction

    // Compare both DUTs with the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            cmp(0, if1.valid_wb, if1.reg_write_wb, if1.mem_to_reg_wb, if1.read_data_wb, if1.alu_out_wb,
                if1.write_reg_wb, if1.pc_plus_4wb, if1.wb_result, if1.retire_cnt);
            cmp(1, if3.valid_wb, if3.reg_write_wb, if3.mem_to_reg_wb, if3.read_data_wb, if3.alu_out_wb,
                if3.write_reg_wb, if3.pc_plus_4wb, if3.wb_result, if3.retire_cnt);
        end
    end

    function automatic ent_t mk(bit rw, bit [1:0] sel, bit [31:0] rd, bit [31:0] alu, bit [4:0] wr,
                                bit [31:0] pc, bit [1:0] ls, bit lu);
        ent_t e;
        e = '{v: 1'b1, rw: rw, sel: sel, rd: rd, alu: alu, wr: wr, pc: pc, ls: ls, lu: lu};
        return e;
    endfunction

    function automatic ent_t rnd();
        ent_t e;
        e.v   = $urandom_range(3) != 0;
        e.rw  = 1'($urandom_range(1));
        e.sel = 2'($urandom_range(3));
        e.rd  = $urandom;
        e.alu = $urandom;
        e.wr  = $urandom_range(7) == 0 ? 5'd0 : 5'($urandom);
        e.pc  = $urandom;
        e.ls  = 2'($urandom_range(3));
        e.lu  = 1'($urandom_range(1));
        return e;
    endfunction

    task automatic drive(ent_t e, bit st, bit fl, bit r);
        cur = e;
        cur_st = st;
        cur_fl = fl;
        cur_rst = r;
        @(negedge clk);
    endtask

    task automatic zero_outputs(string n, logic v, logic rw, logic [1:0] sel, logic [31:0] rd, logic [31:0] alu,
                                logic [4:0] wr, logic [31:0] pc, logic [31:0] res, logic [31:0] c);
        chk({n, " reset valid_wb"}, 32'(v), 0);
        chk({n, " reset reg_write_wb"}, 32'(rw), 0);
        chk({n, " reset mem_to_reg_wb"}, 32'(sel), 0);
        chk({n, " reset read_data_wb"}, rd, 0);
        chk({n, " reset alu_out_wb"}, alu, 0);
        chk({n, " reset write_reg_wb"}, 32'(wr), 0);
        chk({n, " reset pc_plus_4wb"}, pc, 0);
        chk({n, " reset wb_result"}, res, 0);
        chk({n, " reset retire_cnt"}, c, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t seq [7];
        bit   st  [7];
        bit   ev  [7];
        int   ewr [7];

        // Reset held for two edges with random inputs
        drive(rnd(), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
        drive(rnd(), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
        zero_outputs("d1", if1.valid_wb, if1.reg_write_wb, if1.mem_to_reg_wb, if1.read_data_wb, if1.alu_out_wb,
                     if1.write_reg_wb, if1.pc_plus_4wb, if1.wb_result, if1.retire_cnt);
        zero_outputs("d3", if3.valid_wb, if3.reg_write_wb, if3.mem_to_reg_wb, if3.read_data_wb, if3.alu_out_wb,
                     if3.write_reg_wb, if3.pc_plus_4wb, if3.wb_result, if3.retire_cnt);
        cmp_on = 1'b1;

        // DEPTH=1 pass-through, counted on the edge it leaves WB
        drive(mk(1, 0, 0, 32'h1234, 8, 0, 0, 0), 0, 0, 0);
        chk("pass reg_write_wb", 32'(if1.reg_write_wb), 1);
        chk("pass wb_result", if1.wb_result, 32'h1234);
        drive('0, 0, 0, 0);
        chk("pass retire_cnt", if1.retire_cnt, 1);

        // DEPTH=3 latency, no stall: A,B,C out after edges 3,4,5
        drive('0, 0, 0, 1);
        seq = '{mk(1,0,0,1,1,0,0,0), mk(1,0,0,2,2,0,0,0), mk(1,0,0,3,3,0,0,0), '0, '0, '0, '0};
        ev  = '{0, 0, 1, 1, 1, 0, 0};
        ewr = '{0, 0, 1, 2, 3, 0, 0};
        for (int i = 0; i < 6; i++) begin
            drive(seq[i], 0, 0, 0);
            chk($sformatf("lat valid e%0d", i + 1), 32'(if3.valid_wb), 32'(ev[i]));
            if (ev[i]) chk($sformatf("lat write_reg e%0d", i + 1), 32'(if3.write_reg_wb), 32'(ewr[i]));
        end
        chk("lat retire_cnt", if3.retire_cnt, 3);

        // Same burst with a stall at edge 2: everything one edge later
        drive('0, 0, 0, 1);
        seq = '{mk(1,0,0,1,1,0,0,0), mk(1,0,0,2,2,0,0,0), mk(1,0,0,2,2,0,0,0), mk(1,0,0,3,3,0,0,0), '0, '0, '0};
        st  = '{0, 1, 0, 0, 0, 0, 0};
        ev  = '{0, 0, 0, 1, 1, 1, 0};
        ewr = '{0, 0, 0, 1, 2, 3, 0};
        for (int i = 0; i < 7; i++) begin
            drive(seq[i], st[i], 0, 0);
            chk($sformatf("stall valid e%0d", i + 1), 32'(if3.valid_wb), 32'(ev[i]));
            if (ev[i]) chk($sformatf("stall write_reg e%0d", i + 1), 32'(if3.write_reg_wb), 32'(ewr[i]));
        end
        chk("stall retire_cnt", if3.retire_cnt, 3);

        // Flush together with stall kills both in-flight instructions
        drive('0, 0, 0, 1);
        drive(mk(1,0,0,1,1,0,0,0), 0, 0, 0);
        drive(mk(1,0,0,2,2,0,0,0), 0, 0, 0);
        drive(mk(1,0,0,3,3,0,0,0), 1, 1, 0);
        chk("flush valid_wb", 32'(if3.valid_wb), 0);
        chk("flush reg_write_wb", 32'(if3.reg_write_wb), 0);
        for (int i = 0; i < 4; i++) drive('0, 0, 0, 0);
        chk("flush valid_wb later", 32'(if3.valid_wb), 0);
        chk("flush retire_cnt", if3.retire_cnt, 0);

        // $zero destination never writes; PC+4 select
        drive('0, 0, 0, 1);
        drive(mk(1, 0, 0, 5, 0, 0, 0, 0), 0, 0, 0);
        chk("zero valid_wb", 32'(if1.valid_wb), 1);
        chk("zero reg_write_wb", 32'(if1.reg_write_wb), 0);
        drive(mk(1, 2, 0, 7, 31, 32'h0040_0004, 0, 0), 0, 0, 0);
        chk("pc4 wb_result", if1.wb_result, 32'h0040_0004);
        chk("zero retire_cnt", if1.retire_cnt, 0);
        drive('0, 0, 0, 0);
        chk("pc4 retire_cnt", if1.retire_cnt, 1);

`ifdef MEM_WB_LOAD_EXT_EN
        // Byte/half extension of 0x80FF7F01
        drive('0, 0, 0, 1);
        drive(mk(1, 1, 32'h80FF_7F01, 32'h100, 1, 0, 2, 0), 0, 0, 0);
        chk("ext byte0 signed", if1.wb_result, 32'hFFFF_FF80);
        drive(mk(1, 1, 32'h80FF_7F01, 32'h103, 1, 0, 2, 1), 0, 0, 0);
        chk("ext byte3 unsigned", if1.wb_result, 32'h0000_0001);
        drive(mk(1, 1, 32'h80FF_7F01, 32'h102, 1, 0, 1, 0), 0, 0, 0);
        chk("ext half2 signed", if1.wb_result, 32'h0000_7F01);
        drive(mk(1, 1, 32'h80FF_7F01, 32'h101, 1, 0, 1, 0), 0, 0, 0);
        chk("ext half odd raw", if1.read_data_wb, 32'h80FF_7F01);
`endif

        // Randomised traffic with occasional stall, flush and reset
        for (int i = 0; i < 3000; i++)
            drive(rnd(), $urandom_range(4) == 0, $urandom_range(19) == 0, $urandom_range(99) == 0);
        for (int i = 0; i < 4; i++) drive('0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
